axi4_clint_slave: RTL and testbench

- AXI4 single-beat responder (slave end of the CPU's cacheless data port) implementing a core-local interruptor: msip, mtimecmp, mtime.
- Sits on the peripheral side of the CPU's cacheless port.
- Drives the machine timer/software interrupt lines and the 64-bit rdtime value back into the CPU.

---
 rtl/axi4_clint_slave_if.sv | 41 ++++
 rtl/axi4_clint_slave.sv | 194 +++++++++++++++++++
 tb/tb_axi4_clint_slave.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_clint_slave_if.sv
// AXI4 single-beat bus bundle between the CPU's cacheless data port (master)
// and the core-local interruptor (slave).
// Ports: AW channel (awvalid/awready/awaddr/awsize), W channel
// (wvalid/wready/wdata/wstrb/wlast), B channel (bvalid/bready/bresp),
// AR channel (arvalid/arready/araddr/arsize), R channel
// (rvalid/rready/rdata/rresp/rlast).
interface axi4_clint_slave_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport slave (
    input  awvalid, awaddr, awsize, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arsize, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );

  modport master (
    output awvalid, awaddr, awsize, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arsize, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi4_clint_slave.sv
// Core-local interruptor behind an AXI4 single-beat slave port.
// Holds msip, mtimecmp and a prescaled free-running mtime; drives the machine
// timer/software interrupt lines and the rdtime value back to the CPU.
// Ports:
//   clk            - clock
//   reset          - asynchronous active-low reset
//   axi_dp         - AXI4 slave bundle (see axi4_clint_slave_if)
//   mtime          - current time for the CPU rdtime input
//   int_m_timer    - registered (mtime >= mtimecmp), unsigned 64-bit
//   int_m_software - msip bit 0
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); commit when both are held
// W_RESP | write response pending, bvalid held until bready
// R_IDLE | arready high, read data registered on the AR handshake
// R_DATA | rvalid/rlast high, rdata/rresp held until rready
module axi4_clint_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  axi4_clint_slave_if.slave        axi_dp,
  output logic [63:0]              mtime,
  output logic                     int_m_timer,
  output logic                     int_m_software
);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  localparam logic [12:0] SEL_MSIP     = 13'h0000; // offset 0x0000 >> 3
  localparam logic [12:0] SEL_MTIMECMP = 13'h0800; // offset 0x4000 >> 3
  localparam logic [12:0] SEL_MTIME    = 13'h17FF; // offset 0xBFF8 >> 3

  w_state_t    w_state, w_state_nxt;
  r_state_t    r_state, r_state_nxt;
  logic        aw_got, w_got, aw_got_nxt, w_got_nxt;
  logic [31:0] aw_addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [63:0] rdata_q;
  logic        msip, msip_nxt;
  logic [63:0] mtimecmp, mtimecmp_nxt, mtime_nxt;
  logic [31:0] prescaler;
  logic        tick;

  // Handshakes depend only on state, never on the ready outputs themselves.
  logic aw_rdy, w_rdy, aw_hs, w_hs, ar_hs, wr_commit;
  assign aw_rdy = (w_state == W_IDLE) && !aw_got;
  assign w_rdy  = (w_state == W_IDLE) && !w_got;
  assign aw_hs  = axi_dp.awvalid && aw_rdy;
  assign w_hs   = axi_dp.wvalid && w_rdy;
  assign ar_hs  = axi_dp.arvalid && (r_state == R_IDLE);

  // The write may commit in the same cycle the last half arrives, so the
  // effective address/data bypass the capture registers.
  logic [31:0] wr_addr, wr_off, rd_off;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  assign wr_addr = aw_got ? aw_addr_q : axi_dp.awaddr;
  assign wr_data = w_got ? wdata_q : axi_dp.wdata;
  assign wr_strb = w_got ? wstrb_q : axi_dp.wstrb;
  assign wr_off  = wr_addr - BASE_ADDR;
  assign rd_off  = axi_dp.araddr - BASE_ADDR;

  logic wr_msip, wr_cmp, wr_time, wr_err;
  logic rd_msip, rd_cmp, rd_time;
  assign wr_msip = (wr_off[31:16] == 16'h0) && (wr_off[15:3] == SEL_MSIP);
  assign wr_cmp  = (wr_off[31:16] == 16'h0) && (wr_off[15:3] == SEL_MTIMECMP);
  assign wr_time = (wr_off[31:16] == 16'h0) && (wr_off[15:3] == SEL_MTIME);
  assign wr_err  = !(wr_msip || wr_cmp || wr_time);
  assign rd_msip = (rd_off[31:16] == 16'h0) && (rd_off[15:3] == SEL_MSIP);
  assign rd_cmp  = (rd_off[31:16] == 16'h0) && (rd_off[15:3] == SEL_MTIMECMP);
  assign rd_time = (rd_off[31:16] == 16'h0) && (rd_off[15:3] == SEL_MTIME);

  logic unused_bits;
  assign unused_bits = ^{wr_off[2:0], rd_off[2:0], axi_dp.awsize, axi_dp.wlast,
                         axi_dp.arsize};

  function automatic logic [63:0] merge(input logic [63:0] old_v,
                                        input logic [63:0] new_v,
                                        input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      aw_got  <= aw_got_nxt;
      w_got   <= w_got_nxt;
      if (aw_hs) aw_addr_q <= axi_dp.awaddr;
      if (w_hs) begin
        wdata_q <= axi_dp.wdata;
        wstrb_q <= axi_dp.wstrb;
      end
      if (wr_commit) bresp_q <= wr_err ? 2'b10 : 2'b00;
      if (ar_hs) begin
        rresp_q <= (rd_msip || rd_cmp || rd_time) ? 2'b00 : 2'b10;
        rdata_q <= rd_msip ? {63'h0, msip} :
                   rd_cmp  ? mtimecmp :
                   rd_time ? mtime : 64'h0;
      end
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    aw_got_nxt  = aw_got;
    w_got_nxt   = w_got;
    wr_commit   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) aw_got_nxt = 1'b1;
        if (w_hs) w_got_nxt = 1'b1;
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          wr_commit   = 1'b1;
          aw_got_nxt  = 1'b0;
          w_got_nxt   = 1'b0;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: if (axi_dp.bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (axi_dp.arvalid) r_state_nxt = R_DATA;
      R_DATA:  if (axi_dp.rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign axi_dp.awready = aw_rdy;
  assign axi_dp.wready  = w_rdy;
  assign axi_dp.bvalid  = (w_state == W_RESP);
  assign axi_dp.bresp   = bresp_q;
  assign axi_dp.arready = (r_state == R_IDLE);
  assign axi_dp.rvalid  = (r_state == R_DATA);
  assign axi_dp.rlast   = (r_state == R_DATA);
  assign axi_dp.rdata   = rdata_q;
  assign axi_dp.rresp   = rresp_q;

  // A bus write to mtime replaces that cycle's increment; unwritten bytes keep
  // the pre-increment value.
  always_comb begin
    tick         = (prescaler == 32'(TICK_DIV - 1));
    msip_nxt     = msip;
    mtimecmp_nxt = mtimecmp;
    mtime_nxt    = tick ? mtime + 64'd1 : mtime;
    if (wr_commit) begin
      if (wr_msip && wr_strb[0]) msip_nxt = wr_data[0];
      if (wr_cmp) mtimecmp_nxt = merge(mtimecmp, wr_data, wr_strb);
      if (wr_time) mtime_nxt = merge(mtime, wr_data, wr_strb);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msip        <= 1'b0;
      mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime       <= 64'h0;
      prescaler   <= 32'h0;
      int_m_timer <= 1'b0;
    end else begin
      msip        <= msip_nxt;
      mtimecmp    <= mtimecmp_nxt;
      mtime       <= mtime_nxt;
      prescaler   <= tick ? 32'h0 : prescaler + 32'h1;
      int_m_timer <= (mtime_nxt >= mtimecmp_nxt);
    end
  end

  assign int_m_software = msip;
endmodule

// File: tb/tb_axi4_clint_slave.sv
module tb_axi4_clint_slave;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  axi4_clint_slave_if ifc ();
  axi4_clint_slave_if ifc1 ();
  logic [63:0] mtime, mtime1;
  logic        int_t, int_s, int1_t, int1_s;

  axi4_clint_slave #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(100)) u_dut (
    .clk(clk), .reset(reset), .axi_dp(ifc.slave), .mtime(mtime),
    .int_m_timer(int_t), .int_m_software(int_s));

  axi4_clint_slave #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .axi_dp(ifc1.slave), .mtime(mtime1),
    .int_m_timer(int1_t), .int_m_software(int1_s));

  localparam logic [31:0] A_MSIP = 32'h0200_0000;
  localparam logic [31:0] A_CMP  = 32'h0200_4000;
  localparam logic [31:0] A_TIME = 32'h0200_BFF8;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  int checks = 0;
  int errors = 0;

  logic [1:0]  wr_q[$];
  logic [65:0] rd_q[$];
  logic [1:0]  exp_b;
  logic [65:0] exp_r;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic        sw;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: responses are compared when the DUT completes a handshake.
  always @(negedge clk) begin
    #1;
    if (reset && ifc.bvalid && ifc.bready) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got bresp %b with empty queue", ifc.bresp);
      end else begin
        exp_b = wr_q.pop_front();
        if (ifc.bresp !== exp_b) begin
          errors++;
          $display("FAIL bresp: got %b expected %b", ifc.bresp, exp_b);
        end
      end
    end
    if (reset && ifc.rvalid && ifc.rready) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: got rdata %h with empty queue", ifc.rdata);
      end else begin
        exp_r = rd_q.pop_front();
        if ({ifc.rresp, ifc.rdata} !== exp_r) begin
          errors++;
          $display("FAIL rdata: got resp %b data %h expected resp %b data %h",
                   ifc.rresp, ifc.rdata, exp_r[65:64], exp_r[63:0]);
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input int w_gap, input int b_hold,
                           input logic [1:0] exp_resp);
    int  cw;
    bit  got_b;
    logic aw_f, w_f;
    wr_q.push_back(exp_resp);
    @(negedge clk);
    ifc.awvalid = 1'b1;
    ifc.awaddr  = addr;
    ifc.bready  = 1'b0;
    cw = -1;
    got_b = 1'b0;
    for (int cyc = 0; cyc < 40 && !got_b; cyc++) begin
      if (cyc == w_gap) begin
        ifc.wvalid = 1'b1;
        ifc.wdata  = data;
        ifc.wstrb  = strb;
      end
      if (ifc.bvalid) begin
        got_b = 1'b1;
        chk("b_latency", 64'(cyc - cw), 64'd1);
      end else begin
        aw_f = ifc.awvalid && ifc.awready;
        w_f  = ifc.wvalid && ifc.wready;
        if (w_f) cw = cyc;
        @(negedge clk);
        if (aw_f) ifc.awvalid = 1'b0;
        if (w_f) ifc.wvalid = 1'b0;
      end
    end
    if (!got_b) begin
      checks++;
      errors++;
      $display("FAIL b_timeout: no bvalid for write to %h", addr);
      ifc.awvalid = 1'b0;
      ifc.wvalid  = 1'b0;
    end
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      chk("b_hold_valid", 64'(ifc.bvalid), 64'd1);
      chk("b_hold_resp", 64'(ifc.bresp), 64'(exp_resp));
    end
    ifc.bready = 1'b1;
    @(negedge clk);
    ifc.bready = 1'b0;
    chk("b_drop", 64'(ifc.bvalid), 64'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                          input logic [63:0] exp_data);
    bit   got_r;
    logic ar_f;
    rd_q.push_back({exp_resp, exp_data});
    @(negedge clk);
    ifc.arvalid = 1'b1;
    ifc.araddr  = addr;
    ifc.rready  = 1'b1;
    got_r = 1'b0;
    for (int cyc = 0; cyc < 40 && !got_r; cyc++) begin
      if (ifc.rvalid) begin
        got_r = 1'b1;
        chk("rlast", 64'(ifc.rlast), 64'd1);
      end else begin
        ar_f = ifc.arvalid && ifc.arready;
        @(negedge clk);
        if (ar_f) ifc.arvalid = 1'b0;
      end
    end
    if (!got_r) begin
      checks++;
      errors++;
      $display("FAIL r_timeout: no rvalid for read of %h", addr);
      ifc.arvalid = 1'b0;
    end
    @(negedge clk);
    ifc.rready = 1'b0;
    chk("r_drop", 64'(ifc.rvalid), 64'd0);
  endtask

  // Single write on the TICK_DIV=1 instance; returns at the negedge after commit.
  task automatic w1(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    @(negedge clk);
    ifc1.awvalid = 1'b1; ifc1.awaddr = addr;
    ifc1.wvalid  = 1'b1; ifc1.wdata  = data; ifc1.wstrb = strb;
    @(negedge clk);
    ifc1.awvalid = 1'b0;
    ifc1.wvalid  = 1'b0;
  endtask

  initial begin
    int n;
    ifc.awvalid = 0; ifc.awaddr = 0; ifc.awsize = 3'd3; ifc.wvalid = 0; ifc.wdata = 0;
    ifc.wstrb = 0; ifc.wlast = 1; ifc.bready = 0; ifc.arvalid = 0; ifc.araddr = 0;
    ifc.arsize = 3'd3; ifc.rready = 0;
    ifc1.awvalid = 0; ifc1.awaddr = 0; ifc1.awsize = 3'd3; ifc1.wvalid = 0; ifc1.wdata = 0;
    ifc1.wstrb = 0; ifc1.wlast = 1; ifc1.bready = 1; ifc1.arvalid = 0; ifc1.araddr = 0;
    ifc1.arsize = 3'd3; ifc1.rready = 1;

    vecs[0]  = '{1'b1, A_MSIP, 64'h1, 8'h01, 2'b00, 64'h0, 1'b1};
    vecs[1]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 2'b00, 64'h1, 1'b1};
    vecs[2]  = '{1'b1, A_MSIP, 64'h0, 8'h00, 2'b00, 64'h0, 1'b1};
    vecs[3]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 2'b00, 64'h1, 1'b1};
    vecs[4]  = '{1'b0, 32'h0200_1000, 64'h0, 8'h00, 2'b10, 64'h0, 1'b1};
    vecs[5]  = '{1'b1, 32'h0300_0000, ONES, 8'hFF, 2'b10, 64'h0, 1'b1};
    vecs[6]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 2'b00, 64'h1, 1'b1};
    vecs[7]  = '{1'b0, A_CMP, 64'h0, 8'h00, 2'b00, 64'd5, 1'b1};
    vecs[8]  = '{1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 2'b00, 64'h0, 1'b0};
    vecs[9]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 2'b00, 64'h0, 1'b0};
    vecs[10] = '{1'b1, A_MSIP, ONES, 8'hFF, 2'b00, 64'h0, 1'b1};
    vecs[11] = '{1'b0, 32'h0200_0004, 64'h0, 8'h00, 2'b00, 64'h1, 1'b1};
    vecs[12] = '{1'b0, 32'h01FF_FFF8, 64'h0, 8'h00, 2'b10, 64'h0, 1'b1};
    vecs[13] = '{1'b0, 32'h0201_0000, 64'h0, 8'h00, 2'b10, 64'h0, 1'b1};
    vecs[14] = '{1'b1, 32'h0200_4008, 64'h0, 8'hFF, 2'b10, 64'h0, 1'b1};
    vecs[15] = '{1'b0, A_CMP, 64'h0, 8'h00, 2'b00, 64'd5, 1'b1};
    vecs[16] = '{1'b1, 32'h0200_4004, 64'h9, 8'h01, 2'b00, 64'h0, 1'b1};
    vecs[17] = '{1'b0, A_CMP, 64'h0, 8'h00, 2'b00, 64'd9, 1'b1};

    // Reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (250) @(negedge clk);
    chk("idle_mtime", mtime, 64'd2);
    chk("idle_timer", 64'(int_t), 64'd0);
    chk("idle_sw", 64'(int_s), 64'd0);
    chk("idle_awready", 64'(ifc.awready), 64'd1);
    chk("idle_wready", 64'(ifc.wready), 64'd1);
    chk("idle_arready", 64'(ifc.arready), 64'd1);
    chk("idle_bvalid", 64'(ifc.bvalid), 64'd0);
    chk("idle_rvalid", 64'(ifc.rvalid), 64'd0);
    chk("idle_rlast", 64'(ifc.rlast), 64'd0);

    // TICK_DIV=1 instance: wrap and partial writes of mtime
    w1(A_TIME, ONES, 8'hFF);
    chk("t1_write_all_ones", mtime1, ONES);
    @(negedge clk);
    chk("t1_wrap", mtime1, 64'd0);
    w1(A_TIME, 64'h0000_00A5_0000_0000, 8'hFF);
    chk("t1_full_write", mtime1, 64'h0000_00A5_0000_0000);
    w1(A_TIME, 64'h0000_0000_1234_5678, 8'h0F);
    chk("t1_partial_write", mtime1, 64'h0000_00A5_1234_5678);
    @(negedge clk);
    chk("t1_after_partial", mtime1, 64'h0000_00A5_1234_5679);

    // Concurrent AW+W+AR on mtimecmp: read sees the old value
    wr_q.push_back(2'b00);
    rd_q.push_back({2'b00, ONES});
    @(negedge clk);
    ifc.awvalid = 1; ifc.awaddr = A_CMP;
    ifc.wvalid = 1; ifc.wdata = 64'd7; ifc.wstrb = 8'hFF;
    ifc.arvalid = 1; ifc.araddr = A_CMP;
    ifc.bready = 1; ifc.rready = 1;
    @(negedge clk);
    ifc.awvalid = 0; ifc.wvalid = 0; ifc.arvalid = 0;
    chk("conc_bvalid", 64'(ifc.bvalid), 64'd1);
    chk("conc_rvalid", 64'(ifc.rvalid), 64'd1);
    @(negedge clk);
    ifc.bready = 0; ifc.rready = 0;
    chk("conc_b_drop", 64'(ifc.bvalid), 64'd0);
    chk("conc_r_drop", 64'(ifc.rvalid), 64'd0);
    axi_read(A_CMP, 2'b00, 64'd7);

    // mtimecmp=5 with AW first, W three cycles later, bready held off
    axi_write(A_CMP, 64'd5, 8'hFF, 3, 4, 2'b00);
    n = 0;
    while (mtime != 64'd4 && n < 2000) begin @(negedge clk); n++; end
    chk("reach_mtime4", mtime, 64'd4);
    chk("timer_at4", 64'(int_t), 64'd0);
    n = 0;
    while (mtime != 64'd5 && n < 2000) begin @(negedge clk); n++; end
    chk("reach_mtime5", mtime, 64'd5);
    chk("timer_at5", 64'(int_t), 64'd1);

    // Table of single accesses
    foreach (vecs[i]) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, 0, vecs[i].resp);
      else axi_read(vecs[i].addr, vecs[i].resp, vecs[i].rdata);
      chk($sformatf("vec%0d_sw", i), 64'(int_s), 64'(vecs[i].sw));
    end

    // Reset while a write response is pending
    @(negedge clk);
    ifc.awvalid = 1; ifc.awaddr = A_CMP;
    ifc.wvalid = 1; ifc.wdata = 64'd3; ifc.wstrb = 8'hFF;
    ifc.bready = 0;
    @(negedge clk);
    ifc.awvalid = 0; ifc.wvalid = 0;
    chk("rst_pre_bvalid", 64'(ifc.bvalid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_bvalid", 64'(ifc.bvalid), 64'd0);
    chk("rst_awready", 64'(ifc.awready), 64'd1);
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_sw", 64'(int_s), 64'd0);
    chk("rst_timer", 64'(int_t), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    axi_read(A_CMP, 2'b00, ONES);
    axi_read(A_MSIP, 2'b00, 64'd0);

    repeat (2) @(negedge clk);
    chk("sb_wr_empty", 64'(wr_q.size()), 64'd0);
    chk("sb_rd_empty", 64'(rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
